// File: rtl/palette_pkg.sv
`default_nettype none
// ============================================================================
// Module   : palette_pkg
// Brief    : Shared transform-mode encodings and default palette colour helper.
// Revision : 1.0 - initial release
// ============================================================================
package palette_pkg;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_GRAY   = 2'b10;

    localparam int MAX_CH_W  = 32;
    localparam int MAX_RGB_W = 3 * MAX_CH_W;

    // Index bit 0 lights B, bit 1 lights G, bit 2 lights R; higher bits ignored.
    function automatic logic [MAX_RGB_W-1:0] default_colour(input int index, input int ch_w);
        logic [MAX_RGB_W-1:0] colour;
        colour = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int b = 0; b < MAX_CH_W; b++) begin
                if (b < ch_w) begin
                    colour = colour | (MAX_RGB_W'((index >> ch) & 1) << (ch * ch_w + b));
                end
            end
        end
        return colour;
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_lut_if.sv
`default_nettype none
// ============================================================================
// Module   : palette_lut_if
// Brief    : Request, response and table-programming bus of the palette LUT.
// Revision : 1.0 - initial release
// ============================================================================
interface palette_lut_if #(
    parameter int INDEX_W = 3,
    parameter int RGB_W   = 24
);
    logic               in_valid;
    logic               in_ready;
    logic [INDEX_W-1:0] in_index;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [RGB_W-1:0]   rgb;
    logic               wr_en;
    logic [INDEX_W-1:0] wr_index;
    logic [RGB_W-1:0]   wr_data;
    logic               restore;

    modport master (
        output in_valid, in_index, in_mode, out_ready, wr_en, wr_index, wr_data, restore,
        input  in_ready, out_valid, rgb
    );

    modport slave (
        input  in_valid, in_index, in_mode, out_ready, wr_en, wr_index, wr_data, restore,
        output in_ready, out_valid, rgb
    );
endinterface
`default_nettype wire

// File: rtl/palette_xform.sv
`default_nettype none
// ============================================================================
// Module   : palette_xform
// Brief    : Combinational output transform: normal, invert or grayscale.
// Revision : 1.0 - initial release
// ============================================================================
module palette_xform
    import palette_pkg::*;
#(
    parameter int RGB_W = 24
) (
    input  wire logic [RGB_W-1:0] entry,
    input  wire logic [1:0]       mode,
    output logic      [RGB_W-1:0] rgb
);
    localparam int CH_W = RGB_W / 3;

    logic [CH_W-1:0] w_r;
    logic [CH_W-1:0] w_g;
    logic [CH_W-1:0] w_b;
    logic [CH_W+1:0] w_sum;
    logic [CH_W-1:0] w_y;

    assign w_r = entry[3*CH_W-1:2*CH_W];
    assign w_g = entry[2*CH_W-1:CH_W];
    assign w_b = entry[CH_W-1:0];

    // Two extra bits hold the worst case 4*(2^CH_W - 1) without overflow.
    assign w_sum = {2'b00, w_r} + {1'b0, w_g, 1'b0} + {2'b00, w_b};
    assign w_y   = CH_W'(w_sum >> 2);

    always_comb begin
        rgb = entry;
        case (mode)
            MODE_INVERT: rgb = ~entry;
            MODE_GRAY:   rgb = {w_y, w_y, w_y};
            default:     rgb = entry;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/palette_lut.sv
`default_nettype none
// ============================================================================
// Module   : palette_lut
// Brief    : Run-time programmable index-to-RGB palette with valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module palette_lut
    import palette_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int RGB_W   = 24
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    palette_lut_if.slave  bus
);
    localparam int DEPTH = 2 ** INDEX_W;
    localparam int CH_W  = RGB_W / 3;

    logic [RGB_W-1:0] table_q [DEPTH];
    logic [RGB_W-1:0] table_d [DEPTH];
    logic [RGB_W-1:0] w_def_tab [DEPTH];
    logic             out_valid_q;
    logic             out_valid_d;
    logic [RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0] rgb_d;
    logic             w_accept;
    logic [RGB_W-1:0] w_lookup;
    logic [RGB_W-1:0] w_xform;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_default
            assign w_def_tab[i] = RGB_W'(default_colour(i, CH_W));
        end
    endgenerate

    // Next table state; reading it gives write-first and restore-first forwarding.
    always_comb begin
        table_d = table_q;
        if (bus.restore) begin
            table_d = w_def_tab;
        end else if (bus.wr_en) begin
            table_d[bus.wr_index] = bus.wr_data;
        end
    end

    assign w_lookup     = table_d[bus.in_index];
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    palette_xform #(
        .RGB_W (RGB_W)
    ) u_xform (
        .entry (w_lookup),
        .mode  (bus.in_mode),
        .rgb   (w_xform)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        rgb_d       = rgb_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            rgb_d       = w_xform;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q     <= w_def_tab;
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            table_q     <= table_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.rgb       = rgb_q;
endmodule
`default_nettype wire

// File: tb/tb_palette_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_palette_lut
// Brief    : Self-checking scoreboard bench for palette_lut (INDEX_W=3, RGB_W=24).
// Revision : 1.0 - initial release
// ============================================================================
module tb_palette_lut;
    logic clk;
    logic rst_n;
    int   checks_total;
    int   checks_passed;

    logic [23:0] mdl_tab [8];
    logic        mdl_valid;
    logic [23:0] exp_q [$];

    palette_lut_if #(.INDEX_W(3), .RGB_W(24)) bus ();

    palette_lut #(
        .INDEX_W (3),
        .RGB_W   (24)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] def_col(input int i);
        return {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
    endfunction

    function automatic logic [23:0] xf(input logic [23:0] e, input logic [1:0] m);
        int y;
        case (m)
            2'b01:   return ~e;
            2'b10: begin
                y = (int'(e[23:16]) + 2 * int'(e[15:8]) + int'(e[7:0])) >> 2;
                return {y[7:0], y[7:0], y[7:0]};
            end
            default: return e;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl_tab[i] = def_col(i);
        mdl_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_index  = '0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_index  = '0;
        bus.wr_data   = '0;
        bus.restore   = 1'b0;
    endtask

    // One clock cycle: drive after a negedge, sample before the posedge, update model.
    task automatic drive_cycle(
        input  logic v, input logic [2:0] idx, input logic [1:0] mode, input logic ordy,
        input  logic wen, input logic [2:0] widx, input logic [23:0] wd, input logic rs,
        output logic fired, output logic [23:0] got, output logic [23:0] exp_v,
        output logic vld_got, output logic vld_exp, output logic rdy_got, output logic rdy_exp
    );
        logic        acc;
        logic [23:0] nxt [8];
        bus.in_valid  = v;
        bus.in_index  = idx;
        bus.in_mode   = mode;
        bus.out_ready = ordy;
        bus.wr_en     = wen;
        bus.wr_index  = widx;
        bus.wr_data   = wd;
        bus.restore   = rs;
        #1;
        rdy_got = bus.in_ready;
        vld_got = bus.out_valid;
        got     = bus.rgb;
        rdy_exp = !mdl_valid || ordy;
        vld_exp = mdl_valid;
        acc     = v && rdy_exp;
        fired   = mdl_valid && ordy;
        exp_v   = '0;
        if (fired && exp_q.size() > 0) exp_v = exp_q.pop_front();
        nxt = mdl_tab;
        if (rs) begin
            for (int i = 0; i < 8; i++) nxt[i] = def_col(i);
        end else if (wen) begin
            nxt[widx] = wd;
        end
        if (acc) exp_q.push_back(xf(nxt[idx], mode));
        mdl_tab   = nxt;
        mdl_valid = acc || (mdl_valid && !ordy);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
        else checks_passed++;
        checks_total++;
        if (bus.rgb !== 24'h0) $display("FAIL reset_rgb: got %h expected 000000", bus.rgb);
        else checks_passed++;
        checks_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
        else checks_passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        logic f, vg, ve, rg, re;
        logic [23:0] g, e;
        logic [23:0] lit [8];
        int n;
        lit = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(i < 8, 3'(i), 2'b00, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, f, g, e, vg, ve, rg, re);
            checks_total++;
            if (vg !== ve) $display("FAIL defaults_valid: cycle %0d got %b expected %b", i, vg, ve);
            else checks_passed++;
            if (f) begin
                checks_total++;
                if (g !== e || n > 7 || g !== lit[n & 7])
                    $display("FAIL defaults_rgb: entry %0d got %h expected %h", n, g, lit[n & 7]);
                else checks_passed++;
                n++;
            end
        end
        checks_total++;
        if (n != 8) $display("FAIL defaults_count: got %0d expected 8", n);
        else checks_passed++;
    endtask

    task automatic test_modes();
        logic f, vg, ve, rg, re;
        logic [23:0] g, e;
        logic [2:0]  s_idx [6];
        logic [1:0]  s_mode [6];
        logic        s_v [6];
        logic        s_w [6];
        logic [23:0] lit [4];
        int n;
        s_v    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        s_idx  = '{3'd7, 3'd4, 3'd6, 3'd0, 3'd2, 3'd0};
        s_mode = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00};
        s_w    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        lit    = '{24'h000000, 24'h3F3F3F, 24'hBFBFBF, 24'h202020};
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(s_v[i], s_idx[i], s_mode[i], 1'b1, s_w[i], 3'd2, 24'h102030, 1'b0,
                        f, g, e, vg, ve, rg, re);
            if (f) begin
                checks_total++;
                if (g !== e || n > 3 || g !== lit[n & 3])
                    $display("FAIL modes_rgb: result %0d got %h expected %h", n, g, lit[n & 3]);
                else checks_passed++;
                n++;
            end
        end
        checks_total++;
        if (n != 4) $display("FAIL modes_count: got %0d expected 4", n);
        else checks_passed++;
    endtask

    task automatic test_collision();
        logic f, vg, ve, rg, re;
        logic [23:0] g, e;
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i < 2, 3'd3, 2'b00, 1'b1, i == 0, 3'd3, 24'h123456, 1'b0,
                        f, g, e, vg, ve, rg, re);
            if (f) begin
                checks_total++;
                if (g !== e || g !== 24'h123456)
                    $display("FAIL collision_rgb: result %0d got %h expected 123456", n, g);
                else checks_passed++;
                n++;
            end
        end
        checks_total++;
        if (n != 2) $display("FAIL collision_count: got %0d expected 2", n);
        else checks_passed++;
    endtask

    task automatic test_stall();
        logic f, vg, ve, rg, re;
        logic [23:0] g, e;
        logic [23:0] lit [3];
        int n;
        lit = '{24'h0000FF, 24'hFF00FF, 24'hFFFF00};
        n = 0;
        drive_cycle(1'b1, 3'd1, 2'b00, 1'b0, 1'b0, 3'd0, 24'h0, 1'b0, f, g, e, vg, ve, rg, re);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 3'd5, 2'b00, 1'b0, 1'b0, 3'd0, 24'h0, 1'b0, f, g, e, vg, ve, rg, re);
            checks_total++;
            if (rg !== 1'b0 || re !== 1'b0) $display("FAIL stall_ready: got %b expected 0", rg);
            else checks_passed++;
            checks_total++;
            if (g !== 24'h0000FF || vg !== 1'b1)
                $display("FAIL stall_hold: got %h/%b expected 0000FF/1", g, vg);
            else checks_passed++;
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(i < 2, (i == 0) ? 3'd5 : 3'd6, 2'b00, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0,
                        f, g, e, vg, ve, rg, re);
            checks_total++;
            if (vg !== ve) $display("FAIL stall_valid: cycle %0d got %b expected %b", i, vg, ve);
            else checks_passed++;
            if (f) begin
                checks_total++;
                if (g !== e || n > 2 || g !== lit[n % 3])
                    $display("FAIL stall_order: result %0d got %h expected %h", n, g, lit[n % 3]);
                else checks_passed++;
                n++;
            end
        end
        checks_total++;
        if (n != 3) $display("FAIL stall_count: got %0d expected 3", n);
        else checks_passed++;
    endtask

    task automatic test_restore();
        logic f, vg, ve, rg, re;
        logic [23:0] g, e;
        logic        s_v [6];
        logic [2:0]  s_idx [6];
        logic        s_w [6];
        logic [2:0]  s_widx [6];
        logic [23:0] s_wd [6];
        logic        s_rs [6];
        logic [23:0] lit [3];
        int n;
        s_v    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        s_idx  = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd1, 3'd0};
        s_w    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        s_widx = '{3'd1, 3'd5, 3'd0, 3'd1, 3'd0, 3'd0};
        s_wd   = '{24'h111111, 24'h555555, 24'h0, 24'hABCDEF, 24'h0, 24'h0};
        s_rs   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        lit    = '{24'h111111, 24'hFF00FF, 24'h0000FF};
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(s_v[i], s_idx[i], 2'b00, 1'b1, s_w[i], s_widx[i], s_wd[i], s_rs[i],
                        f, g, e, vg, ve, rg, re);
            if (f) begin
                checks_total++;
                if (g !== e || n > 2 || g !== lit[n % 3])
                    $display("FAIL restore_rgb: result %0d got %h expected %h", n, g, lit[n % 3]);
                else checks_passed++;
                n++;
            end
        end
        checks_total++;
        if (n != 3) $display("FAIL restore_count: got %0d expected 3", n);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        logic f, vg, ve, rg, re;
        logic [23:0] g, e;
        int n;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            drive_cycle($urandom_range(3) != 0, 3'($urandom), 2'($urandom),
                        (i >= 76) || ($urandom_range(2) != 0),
                        $urandom_range(2) == 0, 3'($urandom), 24'($urandom),
                        $urandom_range(9) == 0, f, g, e, vg, ve, rg, re);
            checks_total++;
            if (vg !== ve || rg !== re)
                $display("FAIL b2b_hs: cycle %0d got v%b r%b expected v%b r%b", i, vg, rg, ve, re);
            else checks_passed++;
            if (f) begin
                checks_total++;
                if (g !== e) $display("FAIL b2b_rgb: cycle %0d got %h expected %h", i, g, e);
                else checks_passed++;
                n++;
            end
        end
        checks_total++;
        if (n < 10) $display("FAIL b2b_count: got %0d expected at least 10", n);
        else checks_passed++;
    endtask

    task automatic test_reset_midstream();
        logic f, vg, ve, rg, re;
        logic [23:0] g, e;
        logic [23:0] lit [2];
        int n;
        lit = '{24'h000000, 24'hFFFFFF};
        drive_cycle(1'b0, 3'd0, 2'b00, 1'b1, 1'b1, 3'd0, 24'hA5A5A5, 1'b0, f, g, e, vg, ve, rg, re);
        drive_cycle(1'b1, 3'd7, 2'b00, 1'b0, 1'b0, 3'd0, 24'h0, 1'b0, f, g, e, vg, ve, rg, re);
        #1;
        checks_total++;
        if (bus.out_valid !== 1'b1) $display("FAIL midrst_pre: got %b expected 1", bus.out_valid);
        else checks_passed++;
        #1 rst_n = 1'b0;
        #1;
        checks_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", bus.out_valid);
        else checks_passed++;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i < 2, (i == 0) ? 3'd0 : 3'd7, 2'b00, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0,
                        f, g, e, vg, ve, rg, re);
            if (f) begin
                checks_total++;
                if (g !== e || n > 1 || g !== lit[n & 1])
                    $display("FAIL midrst_rgb: result %0d got %h expected %h", n, g, lit[n & 1]);
                else checks_passed++;
                n++;
            end
        end
        checks_total++;
        if (n != 2) $display("FAIL midrst_count: got %0d expected 2", n);
        else checks_passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_defaults();
        test_modes();
        test_collision();
        test_stall();
        test_restore();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/palette_lut.md
Name: palette_lut

Overview:
- Parametrised, run-time-programmable colour palette. It is the successor to the fixed 8-entry colour-to-RGB converter.
- Maps an index to an RGB word through a register-based table.
- Entries can be rewritten at run time and restored to defaults on command.
- Applies an optional output transform: normal, invert or grayscale.
- Sits between a pixel-index source and a display or RGB sink, with valid/ready handshakes on both sides.

Parameters:
- INDEX_W, 3, index width; table depth is DEPTH = 2**INDEX_W.
- RGB_W, 24, output word width. Must be divisible by 3; CH_W = RGB_W/3 is the per-channel width; R is the MSB channel.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  read request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_index  input  INDEX_W  palette index to look up.
- in_mode  input  2  transform: 00 normal, 01 invert, 10 grayscale, 11 reserved (treated as normal).
- out_valid  output  1  rgb is valid.
- out_ready  input  1  sink accepts when out_valid && out_ready.
- rgb  output  RGB_W  looked-up, transformed colour.
- wr_en  input  1  write palette entry.
- wr_index  input  INDEX_W  entry to write.
- wr_data  input  RGB_W  new entry value.
- restore  input  1  one-cycle pulse; reloads all entries with defaults.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, rgb=0, every table entry = its default.
- Default entry i: R channel = all-ones if i[2] else 0; G = all-ones if i[1]; B = all-ones if i[0]. For INDEX_W>3 the upper index bits are ignored. Example: 0->000000, 1->0000FF, 4->FF0000, 6->FFFF00, 7->FFFFFF.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational; there is no in_valid->in_ready path.
  - Latency is 1: a request accepted at edge N gives out_valid=1 and rgb valid after edge N.
  - Full throughput with out_ready held high.
- Stall: while out_valid && !out_ready, rgb and out_valid hold stable and no new request is accepted.
- Drain: when out_valid && out_ready and there is no new accept, out_valid drops to 0 at the next edge. rgb keeps its last value.
- in_mode is sampled together with in_index at accept.
- Transform, applied on the looked-up entry E with channels R, G, B:
  - normal: E.
  - invert: bitwise ~E.
  - grayscale: Y = (R + 2*G + B) >> 2, computed in CH_W+2 bits with no overflow. rgb = {Y,Y,Y}.
- Write: when wr_en is high at an edge, entry wr_index <= wr_data.
- Write/read collision: a same-cycle accept of the same index returns wr_data (write-first). Different indices do not interact.
- restore:
  - At the edge, all entries reload their defaults.
  - restore has priority over a simultaneous wr_en, and that write is dropped.
  - A same-cycle accept returns the default value of the entry.
- Reset mid-operation: any pending output is discarded and out_valid goes to 0 asynchronously. Written entries are lost.
- Out-of-range is impossible, since DEPTH = 2**INDEX_W.

Decomposition:
- Package palette_pkg holds:
  - mode constants MODE_NORMAL=2'b00, MODE_INVERT=2'b01, MODE_GRAY=2'b10;
  - function default_colour(index, CH_W).
- One combinational sub-module, palette_xform (params RGB_W; inputs entry and mode; output transformed rgb), holds all transform arithmetic.
- Table storage, the forwarding mux and the handshake register stay in palette_lut.

Test Plan:
- Reset, then accept indices 0..7 in mode 00 with out_ready=1 -> rgb sequence 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF, one per cycle, each 1 cycle after accept.
- Index 7 mode 01 -> 000000. Index 4 mode 10 -> 3F3F3F. Index 6 mode 10 -> BFBFBF. wr_data=102030 to index 2, then read mode 10 -> 202020.
- wr_en with index 3 and data 123456, plus same-cycle accept of index 3 -> rgb=123456. A later read of index 3 -> 123456.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, rgb stable, no accepts. Release -> queued requests appear in order with no drop or duplicate.
- After writes to entries 1 and 5, pulse restore with a simultaneous wr_en to index 1 (data ABCDEF) -> reads of 1 and 5 return 0000FF and FF00FF.
- Assert rst_n=0 mid-stream while out_valid=1 -> out_valid=0 immediately without a clock edge. After release, table reads return defaults.
